// File: rtl/clk_div_meter_pkg.sv
// Shared definitions for the clock divider readback meter: FSM state encoding
// and the default no-edge timeout.
package clk_div_meter_pkg;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meter_state_e;

    localparam logic [31:0] DEFAULT_TIMEOUT = 32'd1000000;

endpackage

// File: rtl/clk_div_meter_if.sv
// Measurement bus between the clock under test / expected ratio and the meter
// results. The meter uses the slave view; whoever drives the clock uses master.
interface clk_div_meter_if #(
    parameter int WIDE = 32
);
    logic            i_Meas;
    logic [WIDE-1:0] i_Div;
    logic [WIDE-1:0] o_Period;
    logic [WIDE-1:0] o_High;
    logic            o_Valid;
    logic            o_Match;
    logic            o_Timeout;

    modport master (
        output i_Meas,
        output i_Div,
        input  o_Period,
        input  o_High,
        input  o_Valid,
        input  o_Match,
        input  o_Timeout
    );

    modport slave (
        input  i_Meas,
        input  i_Div,
        output o_Period,
        output o_High,
        output o_Valid,
        output o_Match,
        output o_Timeout
    );

endinterface

// File: rtl/clk_div_meter_sync_edge.sv
// Two-flop synchronizer for an asynchronous slow clock, plus one more flop so
// rising and falling edges can be detected cleanly in the system clock domain.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/clk_div_meter.sv
// Reads back a divided clock: measures rise-to-rise period and rise-to-fall
// high time in system clock cycles and compares the period to the expected ratio.
module clk_div_meter
    import clk_div_meter_pkg::*;
#(
    parameter int              WIDE    = 32,
    parameter logic [WIDE-1:0] TIMEOUT = WIDE'(DEFAULT_TIMEOUT)
) (
    input  logic           i_Clk,
    input  logic           i_Rst,
    clk_div_meter_if.slave bus
);

    localparam logic [WIDE-1:0] ONE = WIDE'(1);

    logic rise;
    logic fall;

    meter_state_e    state_q,   state_d;
    logic [WIDE-1:0] per_cnt_q, per_cnt_d;
    logic [WIDE-1:0] hi_cnt_q,  hi_cnt_d;
    logic [WIDE-1:0] hi_lat_q,  hi_lat_d;
    logic [WIDE-1:0] period_q,  period_d;
    logic [WIDE-1:0] high_q,    high_d;
    logic            valid_q,   valid_d;
    logic            match_q,   match_d;
    logic            timeout_q, timeout_d;

    sync_edge u_sync_edge (
        .clk  (i_Clk),
        .rst  (i_Rst),
        .din  (bus.i_Meas),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        hi_lat_d  = hi_lat_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        match_d   = match_q;
        timeout_d = timeout_q;

        // Both counters restart on every rise; the high counter only runs while high.
        if (rise) begin
            per_cnt_d = ONE;
            hi_cnt_d  = ONE;
        end else begin
            if (per_cnt_q != TIMEOUT) begin
                per_cnt_d = per_cnt_q + ONE;
            end
            if ((state_q == HIGH) && !fall && (hi_cnt_q != TIMEOUT)) begin
                hi_cnt_d = hi_cnt_q + ONE;
            end
        end

        unique case (state_q)
            ARM: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH, LOW: begin
                if (rise) begin
                    state_d   = HIGH;
                    period_d  = per_cnt_q;
                    high_d    = hi_lat_q;
                    valid_d   = 1'b1;
                    match_d   = (per_cnt_q == bus.i_Div) && (bus.i_Div != ONE);
                    timeout_d = 1'b0;
                end else if (per_cnt_q == TIMEOUT) begin
                    state_d   = ARM;
                    timeout_d = 1'b1;
                end else if ((state_q == HIGH) && fall) begin
                    state_d  = LOW;
                    hi_lat_d = hi_cnt_q;
                end
            end
            default: begin
                state_d = ARM;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= ARM;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            hi_lat_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            hi_lat_q  <= hi_lat_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_Period  = period_q;
    assign bus.o_High    = high_q;
    assign bus.o_Valid   = valid_q;
    assign bus.o_Match   = match_q;
    assign bus.o_Timeout = timeout_q;

endmodule

// File: tb/tb_clk_div_meter.sv
// Bench for clk_div_meter: an edge-timestamp model predicts every output each
// cycle, and directed literal checks pin the expected results of each scenario.
module tb_clk_div_meter;

    localparam int          WIDE = 32;
    localparam logic [31:0] TMO  = 32'd100;

    logic i_Clk = 1'b0;
    logic i_Rst;

    clk_div_meter_if #(.WIDE(WIDE)) bus ();

    clk_div_meter #(
        .WIDE    (WIDE),
        .TIMEOUT (TMO)
    ) dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    always #5 i_Clk = ~i_Clk;

    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   valid_cnt = 0;
    bit   chk_en    = 1'b0;
    bit   t6        = 1'b0;
    logic prev_valid = 1'b0;

    typedef struct {
        int          due;
        bit          pub;
        logic [31:0] per;
        logic [31:0] hi;
    } ev_t;

    ev_t         evq[$];
    ev_t         ev;
    logic        lvl;
    logic        prev_lvl  = 1'b0;
    bit          have_ref  = 1'b0;
    int          rise_t    = 0;
    int          fall_t    = 0;
    logic [31:0] div_s     = '0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_per   = '0;
    logic [31:0] exp_hi    = '0;
    logic        exp_match = 1'b0;
    logic        exp_tmo   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: timestamps of sampled edges; results appear two edges after the sampling edge.
    always @(posedge i_Clk) begin
        cyc++;
        div_s     = bus.i_Div;
        exp_valid = 1'b0;
        if (i_Rst === 1'b1) begin
            prev_lvl  = 1'b0;
            have_ref  = 1'b0;
            evq.delete();
            exp_per   = '0;
            exp_hi    = '0;
            exp_match = 1'b0;
            exp_tmo   = 1'b0;
        end else begin
            lvl = bus.i_Meas;
            if (lvl && !prev_lvl) begin
                if (have_ref) begin
                    ev.due = cyc + 2;
                    ev.pub = 1'b1;
                    ev.per = 32'(cyc - rise_t);
                    ev.hi  = 32'(fall_t - rise_t);
                    evq.push_back(ev);
                end
                have_ref = 1'b1;
                rise_t   = cyc;
            end else begin
                if (!lvl && prev_lvl) fall_t = cyc;
                if (have_ref && ((cyc - rise_t) == int'(TMO))) begin
                    ev.due = cyc + 2;
                    ev.pub = 1'b0;
                    ev.per = '0;
                    ev.hi  = '0;
                    evq.push_back(ev);
                    have_ref = 1'b0;
                end
            end
            prev_lvl = lvl;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                ev = evq.pop_front();
                if (ev.pub) begin
                    exp_valid = 1'b1;
                    exp_per   = ev.per;
                    exp_hi    = ev.hi;
                    exp_match = (ev.per == div_s) && (div_s != 32'd1);
                    exp_tmo   = 1'b0;
                end else begin
                    exp_tmo = 1'b1;
                end
            end
        end
    end

    always @(negedge i_Clk) begin
        if (chk_en) begin
            check("valid",   32'(bus.o_Valid),   32'(exp_valid));
            check("period",  bus.o_Period,       exp_per);
            check("high",    bus.o_High,         exp_hi);
            check("match",   32'(bus.o_Match),   32'(exp_match));
            check("timeout", 32'(bus.o_Timeout), 32'(exp_tmo));
            check("no_x", 32'($isunknown({bus.o_Period, bus.o_High, bus.o_Valid,
                                          bus.o_Match, bus.o_Timeout})), 32'd0);
            check("no_b2b_valid", 32'(bus.o_Valid & prev_valid), 32'd0);
            if (t6 && bus.o_Valid === 1'b1) begin
                check("t6_jitter", 32'((bus.o_Period >= 32'd12) && (bus.o_Period <= 32'd14)), 32'd1);
            end
        end
        prev_valid = bus.o_Valid;
        if (bus.o_Valid === 1'b1) valid_cnt++;
    end

    task automatic hold(input logic v, input int n);
        bus.i_Meas = v;
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    task automatic apply_reset(input int n);
        bus.i_Meas = 1'b0;
        i_Rst      = 1'b1;
        repeat (n) @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;
    endtask

    task automatic check_output_reset(input string tag);
        check({tag, "_period"},  bus.o_Period,         32'd0);
        check({tag, "_high"},    bus.o_High,           32'd0);
        check({tag, "_valid"},   32'(bus.o_Valid),     32'd0);
        check({tag, "_match"},   32'(bus.o_Match),     32'd0);
        check({tag, "_timeout"}, 32'(bus.o_Timeout),   32'd0);
    endtask

    initial begin
        int p;
        i_Rst      = 1'b1;
        bus.i_Meas = 1'b0;
        bus.i_Div  = 32'd10;
        apply_reset(3);
        chk_en = 1'b1;
        check_output_reset("rst");

        // 5 high / 5 low against ratio 10
        valid_cnt = 0;
        wave(5, 5, 3);
        hold(1'b0, 4);
        check("t1_period", bus.o_Period, 32'd10);
        check("t1_high",   bus.o_High,   32'd5);
        check("t1_match",  32'(bus.o_Match), 32'd1);
        check("t1_valids", 32'(valid_cnt), 32'd2);

        // Odd divide 3/2, then a wrong expected ratio
        apply_reset(2);
        bus.i_Div = 32'd5;
        valid_cnt = 0;
        wave(3, 2, 3);
        check("t2_period", bus.o_Period, 32'd5);
        check("t2_high",   bus.o_High,   32'd3);
        check("t2_match",  32'(bus.o_Match), 32'd1);
        bus.i_Div = 32'd7;
        wave(3, 2, 2);
        hold(1'b0, 4);
        check("t2_period_b", bus.o_Period, 32'd5);
        check("t2_match_b",  32'(bus.o_Match), 32'd0);
        check("t2_valids",   32'(valid_cnt), 32'd4);

        // Fastest legal input: toggle every cycle
        apply_reset(2);
        bus.i_Div = 32'd2;
        valid_cnt = 0;
        wave(1, 1, 10);
        hold(1'b0, 4);
        check("t3_period", bus.o_Period, 32'd2);
        check("t3_high",   bus.o_High,   32'd1);
        check("t3_match",  32'(bus.o_Match), 32'd1);
        check("t3_valids", 32'(valid_cnt), 32'd9);

        // Stall after a rise until timeout, then resume
        apply_reset(2);
        bus.i_Div = 32'd10;
        valid_cnt = 0;
        wave(5, 5, 2);
        hold(1'b1, 5);
        hold(1'b0, 110);
        check("t4_timeout", 32'(bus.o_Timeout), 32'd1);
        check("t4_period",  bus.o_Period, 32'd10);
        check("t4_valids",  32'(valid_cnt), 32'd2);
        valid_cnt = 0;
        wave(5, 5, 2);
        hold(1'b0, 4);
        check("t4_timeout_clr", 32'(bus.o_Timeout), 32'd0);
        check("t4_period_b",    bus.o_Period, 32'd10);
        check("t4_valids_b",    32'(valid_cnt), 32'd1);

        // Reset in the middle of a high phase
        apply_reset(2);
        bus.i_Div = 32'd10;
        wave(5, 5, 2);
        check("t5_pre_period", bus.o_Period, 32'd10);
        hold(1'b1, 4);
        apply_reset(1);
        check_output_reset("t5_rst");
        valid_cnt = 0;
        wave(5, 5, 3);
        hold(1'b0, 4);
        check("t5_period", bus.o_Period, 32'd10);
        check("t5_high",   bus.o_High,   32'd5);
        check("t5_valids", 32'(valid_cnt), 32'd2);

        // Period-13 wave at a random phase to the system clock
        apply_reset(2);
        bus.i_Div = 32'd13;
        valid_cnt = 0;
        t6 = 1'b1;
        p = $urandom_range(1, 4);
        if ($urandom_range(0, 1) == 1) p = p + 5;
        @(posedge i_Clk);
        #(p);
        repeat (20) begin
            bus.i_Meas = 1'b1;
            #65;
            bus.i_Meas = 1'b0;
            #65;
        end
        @(posedge i_Clk);
        #1;
        hold(1'b0, 4);
        t6 = 1'b0;
        check("t6_period", bus.o_Period, 32'd13);
        check("t6_match",  32'(bus.o_Match), 32'd1);
        check("t6_valids", 32'(valid_cnt), 32'd19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
